// File: rtl/vtg_pkg.sv
// Shared types and helpers for video_timing_gen: signed sync adjustment,
// clamped porch computation and segment totals.
package vtg_pkg;

  typedef logic signed [3:0] adj_t;

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync may never start inside the active region and must leave at least one unit of back porch.
  function automatic int clamp_porch(input int fp, input int bp, input adj_t adj);
    int p;
    p = fp + int'(adj);
    if (p < 1) p = 1;
    else if (p > fp + bp - 1) p = fp + bp - 1;
    return p;
  endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: position counter with blank/sync decode and event pulses,
// all flags registered from the next count so they line up with pos.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 288,
  parameter int FP     = 21,
  parameter int SYNC   = 31,
  parameter int BP     = 44,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  adj_t             adj,
  output logic [CNT_W-1:0] pos,
  output logic             blk,
  output logic             syn,
  output logic             wrap,
  output logic             start_pulse,
  output logic             blank_pulse
);

  localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] pos_next;
  int               pos_next_i;
  int               sync_lo;
  int               sync_hi;

  assign wrap = en && (pos == LAST);

  always_comb begin
    pos_next = pos;
    if (en) pos_next = (pos == LAST) ? '0 : pos + 1'b1;
    pos_next_i = int'(pos_next);
    sync_lo    = ACTIVE + clamp_porch(FP, BP, adj);
    sync_hi    = sync_lo + SYNC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos         <= '0;
      blk         <= 1'b0;
      syn         <= 1'b1;
      start_pulse <= 1'b0;
      blank_pulse <= 1'b0;
    end else begin
      // Pulses are recomputed every clock so they drop even when en is low.
      start_pulse <= wrap;
      blank_pulse <= en && (pos_next_i == ACTIVE);
      if (en) begin
        pos <= pos_next;
        blk <= (pos_next_i >= ACTIVE);
        syn <= !((pos_next_i >= sync_lo) && (pos_next_i < sync_hi));
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, blanking, active-low syncs, gated RGB and
// line/frame pulses. Define VTG_ADJUST_EN to enable frame-latched sync centering.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 21,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 44,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 21,
  parameter int CNT_W    = 9,
  parameter int RGB_W    = 12
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               CE_PIX,
  input  logic signed [3:0]  H_ADJ,
  input  logic signed [3:0]  V_ADJ,
  input  logic [RGB_W-1:0]   iRGB,
  output logic [CNT_W-1:0]   HPOS,
  output logic [CNT_W-1:0]   VPOS,
  output logic               HBLK,
  output logic               VBLK,
  output logic               HSYN,
  output logic               VSYN,
  output logic [RGB_W-1:0]   oRGB,
  output logic               LINE_START,
  output logic               VBL_IRQ
);

  logic hwrap;
  logic vwrap;
  logic v_en;
  adj_t h_adj_eff;
  adj_t v_adj_eff;
  logic h_blank_pulse_unused;
  logic v_start_pulse_unused;

  assign v_en = CE_PIX & hwrap;

`ifdef VTG_ADJUST_EN
  adj_t h_adj_reg;
  adj_t v_adj_reg;

  // vwrap already implies CE and a horizontal wrap, i.e. the frame start.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      h_adj_reg <= '0;
      v_adj_reg <= '0;
    end else if (vwrap) begin
      h_adj_reg <= H_ADJ;
      v_adj_reg <= V_ADJ;
    end
  end

  assign h_adj_eff = h_adj_reg;
  assign v_adj_eff = v_adj_reg;
`else
  logic adj_inputs_unused;
  assign adj_inputs_unused = ^{H_ADJ, V_ADJ};
  assign h_adj_eff = '0;
  assign v_adj_eff = '0;
`endif

  vtg_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk         (MCLK),
    .rst         (RESET),
    .en          (CE_PIX),
    .adj         (h_adj_eff),
    .pos         (HPOS),
    .blk         (HBLK),
    .syn         (HSYN),
    .wrap        (hwrap),
    .start_pulse (LINE_START),
    .blank_pulse (h_blank_pulse_unused)
  );

  vtg_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk         (MCLK),
    .rst         (RESET),
    .en          (v_en),
    .adj         (v_adj_eff),
    .pos         (VPOS),
    .blk         (VBLK),
    .syn         (VSYN),
    .wrap        (vwrap),
    .start_pulse (v_start_pulse_unused),
    .blank_pulse (VBL_IRQ)
  );

  // Blanking comes from the flags of the pixel being replaced, hence the one-pixel lag.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) oRGB <= '0;
    else if (CE_PIX) oRGB <= (HBLK | VBLK) ? '0 : iRGB;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: small-parameter instance checked against a
// frame-index reference model, plus a default-parameter instance for line geometry.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 4;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 9, RW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic signed [3:0] h_adj = '0;
  logic signed [3:0] v_adj = '0;
  logic [RW-1:0] irgb = '0;

  logic [CW-1:0] hpos, vpos;
  logic hblk, vblk, hsyn, vsyn, line_start, vbl_irq;
  logic [RW-1:0] orgb;

  logic [CW-1:0] d_hpos, d_vpos;
  logic d_hblk, d_vblk, d_hsyn, d_vsyn, d_line_start, d_vbl_irq;
  logic [RW-1:0] d_orgb;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CNT_W(CW), .RGB_W(RW)
  ) dut (
    .MCLK(clk), .RESET(rst), .CE_PIX(ce), .H_ADJ(h_adj), .V_ADJ(v_adj), .iRGB(irgb),
    .HPOS(hpos), .VPOS(vpos), .HBLK(hblk), .VBLK(vblk), .HSYN(hsyn), .VSYN(vsyn),
    .oRGB(orgb), .LINE_START(line_start), .VBL_IRQ(vbl_irq)
  );

  video_timing_gen dut_def (
    .MCLK(clk), .RESET(rst), .CE_PIX(ce), .H_ADJ(h_adj), .V_ADJ(v_adj), .iRGB(irgb),
    .HPOS(d_hpos), .VPOS(d_vpos), .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn), .VSYN(d_vsyn),
    .oRGB(d_orgb), .LINE_START(d_line_start), .VBL_IRQ(d_vbl_irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position is a single CE index within the frame.
  int m_n, m_hadj, m_vadj;
  logic [RW-1:0] m_rgb;
  bit m_ls, m_irq;

  function automatic int porch(input int fp, input int bp, input int adj);
    int p;
    p = fp + adj;
    if (p < 1) p = 1;
    if (p > fp + bp - 1) p = fp + bp - 1;
    return p;
  endfunction

  function automatic int e_h();
    return m_n % HT;
  endfunction

  function automatic int e_v();
    return m_n / HT;
  endfunction

  function automatic bit e_hblk();
    return e_h() >= HA;
  endfunction

  function automatic bit e_vblk();
    return e_v() >= VA;
  endfunction

  function automatic bit e_hsyn();
    int lo;
    lo = HA + porch(HF, HB, m_hadj);
    return !(e_h() >= lo && e_h() < lo + HS);
  endfunction

  function automatic bit e_vsyn();
    int lo;
    lo = VA + porch(VF, VB, m_vadj);
    return !(e_v() >= lo && e_v() < lo + VS);
  endfunction

  task automatic model_reset();
    m_n = 0; m_hadj = 0; m_vadj = 0; m_rgb = '0; m_ls = 0; m_irq = 0;
  endtask

  task automatic cycle(input bit c, input logic [RW-1:0] rgb);
    int oh, ov;
    ce = c;
    irgb = rgb;
    @(posedge clk);
    #1;
    m_ls = 0;
    m_irq = 0;
    if (rst) begin
      model_reset();
    end else if (c) begin
      oh = m_n % HT;
      ov = m_n / HT;
      m_rgb = (oh >= HA || ov >= VA) ? '0 : rgb;
`ifdef VTG_ADJUST_EN
      if (m_n == FT - 1) begin
        m_hadj = int'(h_adj);
        m_vadj = int'(v_adj);
      end
`endif
      m_n = (m_n + 1) % FT;
      m_ls = (e_h() == 0);
      m_irq = (m_n == VA * HT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) cycle(1'b1, RW'($urandom));
    checks++; if (hpos !== '0) begin errors++; $display("FAIL reset_hpos: got %0d expected 0", hpos); end
    checks++; if (vpos !== '0) begin errors++; $display("FAIL reset_vpos: got %0d expected 0", vpos); end
    checks++; if ({hblk, vblk} !== 2'b00) begin errors++; $display("FAIL reset_blank: got %b expected 00", {hblk, vblk}); end
    checks++; if ({hsyn, vsyn} !== 2'b11) begin errors++; $display("FAIL reset_sync: got %b expected 11", {hsyn, vsyn}); end
    checks++; if (orgb !== '0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", orgb); end
    checks++; if ({line_start, vbl_irq} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {line_start, vbl_irq}); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_hline();
    int nblk;
    nblk = 0;
    for (int i = 0; i < HT; i++) begin
      cycle(1'b1, RW'($urandom));
      checks++; if (int'(hpos) !== e_h()) begin errors++; $display("FAIL hline_hpos: got %0d expected %0d", hpos, e_h()); end
      checks++; if (hblk !== e_hblk()) begin errors++; $display("FAIL hline_hblk: hpos %0d got %b expected %b", hpos, hblk, e_hblk()); end
      checks++; if (hsyn !== e_hsyn()) begin errors++; $display("FAIL hline_hsyn: hpos %0d got %b expected %b", hpos, hsyn, e_hsyn()); end
      checks++; if (line_start !== m_ls) begin errors++; $display("FAIL hline_ls: hpos %0d got %b expected %b", hpos, line_start, m_ls); end
      if (hblk) nblk++;
    end
    checks++; if (nblk != HT - HA) begin errors++; $display("FAIL hline_blank_count: got %0d expected %0d", nblk, HT - HA); end
    $display("test_hline done");
  endtask

  task automatic test_frame();
    int nirq, first_irq, second_irq;
    nirq = 0; first_irq = -1; second_irq = -1;
    for (int i = 0; i < 2 * FT; i++) begin
      cycle(1'b1, RW'($urandom));
      checks++; if (int'(vpos) !== e_v()) begin errors++; $display("FAIL frame_vpos: got %0d expected %0d", vpos, e_v()); end
      checks++; if (vblk !== e_vblk()) begin errors++; $display("FAIL frame_vblk: vpos %0d got %b expected %b", vpos, vblk, e_vblk()); end
      checks++; if (vsyn !== e_vsyn()) begin errors++; $display("FAIL frame_vsyn: vpos %0d got %b expected %b", vpos, vsyn, e_vsyn()); end
      checks++; if (vbl_irq !== m_irq) begin errors++; $display("FAIL frame_irq: vpos %0d hpos %0d got %b expected %b", vpos, hpos, vbl_irq, m_irq); end
      if (vbl_irq) begin
        nirq++;
        if (first_irq < 0) first_irq = i; else second_irq = i;
      end
    end
    checks++; if (nirq != 2) begin errors++; $display("FAIL frame_irq_count: got %0d expected 2", nirq); end
    checks++; if (second_irq - first_irq != FT) begin errors++; $display("FAIL frame_length: got %0d expected %0d", second_irq - first_irq, FT); end
    $display("test_frame done");
  endtask

  task automatic test_adjust();
    int adjs[4];
    int lo;
    adjs[0] = 7;
    adjs[1] = -4;
    adjs[2] = int'($urandom_range(0, 15)) - 8;
    adjs[3] = int'($urandom_range(0, 15)) - 8;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < FT && m_n != 40; i++) cycle(1'b1, RW'($urandom));
      checks++; if (m_n != 40) begin errors++; $display("FAIL adjust_align: got %0d expected 40", m_n); end
      h_adj = 4'(adjs[k]);
      v_adj = 4'($urandom_range(0, 15));
      for (int i = 0; i < 100; i++) begin
        cycle(1'b1, RW'($urandom));
        checks++; if (hsyn !== e_hsyn()) begin errors++; $display("FAIL adjust_hsyn: adj %0d hpos %0d got %b expected %b", adjs[k], hpos, hsyn, e_hsyn()); end
        checks++; if (vsyn !== e_vsyn()) begin errors++; $display("FAIL adjust_vsyn: vpos %0d got %b expected %b", vpos, vsyn, e_vsyn()); end
      end
      // Mid-frame change: must not move sync before the next frame start.
      h_adj = 4'($urandom);
      v_adj = 4'($urandom);
      for (int i = 0; i < FT; i++) begin
        cycle(1'b1, RW'($urandom));
        checks++; if (hsyn !== e_hsyn()) begin errors++; $display("FAIL adjust_mid_hsyn: hpos %0d got %b expected %b", hpos, hsyn, e_hsyn()); end
        checks++; if (vsyn !== e_vsyn()) begin errors++; $display("FAIL adjust_mid_vsyn: vpos %0d got %b expected %b", vpos, vsyn, e_vsyn()); end
        if (k < 2) begin
`ifdef VTG_ADJUST_EN
          lo = (k == 0) ? 13 : 9;
          if (m_hadj == adjs[k]) begin
            checks++; if (!hsyn !== (int'(hpos) >= lo && int'(hpos) < lo + 2)) begin errors++; $display("FAIL adjust_clamp: adj %0d hpos %0d got hsyn %b", adjs[k], hpos, hsyn); end
          end
`else
          lo = 10;
          checks++; if (!hsyn !== (int'(hpos) >= lo && int'(hpos) < lo + 2)) begin errors++; $display("FAIL adjust_fixed: hpos %0d got hsyn %b", hpos, hsyn); end
`endif
        end
      end
      $display("test_adjust adj %0d done", adjs[k]);
    end
    h_adj = '0;
    v_adj = '0;
  endtask

  task automatic test_ce_pattern();
    bit pat[4];
    logic [RW-1:0] rgb;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    for (int i = 0; i < 4 * FT / 2; i++) begin
      rgb = ($urandom_range(0, 1) == 1) ? 12'hABC : RW'($urandom);
      cycle(pat[i % 4], rgb);
      checks++; if (int'(hpos) !== e_h() || int'(vpos) !== e_v()) begin errors++; $display("FAIL ce_pos: got %0d/%0d expected %0d/%0d", hpos, vpos, e_h(), e_v()); end
      checks++; if (orgb !== m_rgb) begin errors++; $display("FAIL ce_rgb: got %h expected %h", orgb, m_rgb); end
      checks++; if (hblk !== e_hblk() || vblk !== e_vblk()) begin errors++; $display("FAIL ce_blank: got %b%b expected %b%b", hblk, vblk, e_hblk(), e_vblk()); end
      checks++; if ({line_start, vbl_irq} !== {m_ls, m_irq}) begin errors++; $display("FAIL ce_pulses: got %b%b expected %b%b", line_start, vbl_irq, m_ls, m_irq); end
    end
    $display("test_ce_pattern done");
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < FT + 1 && !(e_h() == 5 && e_v() == 2); i++) cycle(1'b1, 12'hABC);
    checks++; if (!(int'(hpos) == 5 && int'(vpos) == 2)) begin errors++; $display("FAIL midreset_reach: got %0d/%0d expected 5/2", hpos, vpos); end
    checks++; if (orgb !== m_rgb) begin errors++; $display("FAIL midreset_pre_rgb: got %h expected %h", orgb, m_rgb); end
    rst = 1'b1;
    #2;
    checks++; if (hpos !== '0 || vpos !== '0) begin errors++; $display("FAIL midreset_pos: got %0d/%0d expected 0/0", hpos, vpos); end
    checks++; if ({hblk, vblk, hsyn, vsyn} !== 4'b0011) begin errors++; $display("FAIL midreset_flags: got %b expected 0011", {hblk, vblk, hsyn, vsyn}); end
    checks++; if (orgb !== '0) begin errors++; $display("FAIL midreset_rgb: got %h expected 0", orgb); end
    model_reset();
    cycle(1'b1, 12'hABC);
    rst = 1'b0;
    cycle(1'b1, 12'hABC);
    checks++; if (hpos !== 9'd1 || vpos !== 9'd0) begin errors++; $display("FAIL midreset_restart: got %0d/%0d expected 1/0", hpos, vpos); end
    for (int i = 0; i < HT; i++) begin
      cycle(1'b1, RW'($urandom));
      checks++; if (hsyn !== e_hsyn() || int'(hpos) !== e_h()) begin errors++; $display("FAIL midreset_line: hpos %0d got hsyn %b expected %b", hpos, hsyn, e_hsyn()); end
    end
    $display("test_reset_midframe done");
  endtask

  task automatic test_default_line();
    int len, nblk, nsync, first_low, v0;
    bit seen;
    seen = 0;
    for (int i = 0; i < 800 && !seen; i++) begin
      cycle(1'b1, RW'($urandom));
      seen = d_line_start;
    end
    checks++; if (!seen) begin errors++; $display("FAIL default_first_line: got no LINE_START within bound"); end
    v0 = int'(d_vpos);
    len = 0; nblk = 0; nsync = 0; first_low = -1; seen = 0;
    while (len < 400 && !seen) begin
      cycle(1'b1, RW'($urandom));
      len++;
      if (d_hblk) nblk++;
      if (!d_hsyn) begin
        nsync++;
        if (first_low < 0) first_low = int'(d_hpos);
      end
      seen = d_line_start;
    end
    checks++; if (len != 384) begin errors++; $display("FAIL default_line_len: got %0d expected 384", len); end
    checks++; if (nblk != 96) begin errors++; $display("FAIL default_hblk: got %0d expected 96", nblk); end
    checks++; if (nsync != 31) begin errors++; $display("FAIL default_hsync_width: got %0d expected 31", nsync); end
    checks++; if (first_low != 309) begin errors++; $display("FAIL default_hsync_pos: got %0d expected 309", first_low); end
    checks++; if (int'(d_vpos) != (v0 + 1) % 263) begin errors++; $display("FAIL default_vpos_step: got %0d expected %0d", d_vpos, (v0 + 1) % 263); end
    $display("test_default_line done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hline();
    test_frame();
    test_adjust();
    test_ce_pattern();
    test_reset_midframe();
    test_default_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade cores. It produces horizontal and vertical position counters, blanking, active-low syncs, a blank-gated registered RGB path, and line/frame event pulses for the game core and the video output chain. Operation advances on a pixel clock-enable inside the single master clock domain. It adds runtime sync-position adjustment for screen centering, applied at frame boundaries only.

## Interface
- H_ACTIVE, 288: visible pixels per line
- H_FP, 21: horizontal front porch, in pixels
- H_SYNC, 31: horizontal sync width
- H_BP, 44: horizontal back porch
- V_ACTIVE, 224: visible lines per frame
- V_FP, 11 / V_SYNC, 7 / V_BP, 21: vertical front porch, sync and back porch, in lines
- CNT_W, 9: width of the position counters; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- RGB_W, 12: colour bus width
- MCLK  in  1: master clock
- RESET  in  1: asynchronous reset, active-high
- CE_PIX  in  1: pixel enable; all state advances only on MCLK edges where CE_PIX=1
- H_ADJ  in  4: signed horizontal sync shift, in pixels
- V_ADJ  in  4: signed vertical sync shift, in lines
- iRGB  in  RGB_W: pixel colour from the core
- HPOS, VPOS  out  CNT_W: current counters
- HBLK, VBLK  out  1: blanking flags, 1 = blanked
- HSYN, VSYN  out  1: syncs, active-low
- oRGB  out  RGB_W: registered colour, forced to 0 during blanking
- LINE_START  out  1: one-MCLK pulse on the CE cycle where HPOS wraps to 0
- VBL_IRQ  out  1: one-MCLK pulse on the CE cycle where VPOS becomes V_ACTIVE

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Horizontal counter: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter: increments only on the horizontal wrap; counts 0..V_TOTAL-1, then wraps.
- HBLK = (HPOS ≥ H_ACTIVE). VBLK = (VPOS ≥ V_ACTIVE).
- Effective front porch: hfp = clamp(H_FP + H_ADJ_l, 1, H_FP+H_BP-1). vfp is computed the same way from V_FP and V_ADJ_l.
- HSYN = 0 while H_ACTIVE+hfp ≤ HPOS < H_ACTIVE+hfp+H_SYNC. VSYN uses the same rule vertically, evaluated on whole lines.
- Adjustment latch: H_ADJ_l and V_ADJ_l load from the inputs only on the CE cycle where both counters wrap to 0 (frame start). Changing the inputs mid-frame has no effect until the next frame.
- Flag alignment: all flags are registered from the next-count values, so each flag matches the HPOS/VPOS presented in the same cycle.
- oRGB: on each CE, oRGB <= (HBLK|VBLK) ? 0 : iRGB. Blanking is taken from the pre-update flags, so oRGB lags HPOS by one pixel.
- Reset values: counters = 0, HBLK = 0, VBLK = 0, HSYN = 1, VSYN = 1, oRGB = 0, LINE_START = 0, VBL_IRQ = 0, latched adjustments = 0.
- Reset asserted mid-frame forces every register to its reset value immediately. Counting restarts from (0,0) on the first CE after release.
- Without CE_PIX, all outputs hold, except that LINE_START and VBL_IRQ always drop to 0 on the next MCLK.

## Timing
- Position latency: one CE from the counter update to HPOS/VPOS and the flags, all coincident. oRGB is delayed by a further pixel.
- Pulses are exactly one MCLK wide. VBL_IRQ and LINE_START can fire in the same cycle; they are independent.
- Frame period is H_TOTAL × V_TOTAL CE cycles. The defaults give 384 × 263.
- Sync placement is clamped, so sync never enters the active region and always leaves at least one pixel or line of back porch.

## Configuration
- VTG_ADJUST_EN defined: H_ADJ and V_ADJ are latched and used as described above.
- VTG_ADJUST_EN undefined: both inputs are ignored, the latches are not built, hfp = H_FP and vfp = V_FP. Ports remain present so the interface is unchanged.

## Structure
- Package vtg_pkg holds:
  - the typedef for the signed 4-bit adjustment;
  - a function computing the clamped porch;
  - a localparam-style helper computing totals from the four segment widths.
- Sub-module vtg_axis: one counter with its blank and sync decode, instantiated twice.
  - Horizontal instance is enabled by CE_PIX.
  - Vertical instance is enabled by CE_PIX & hwrap.

## Test plan
All scenarios use small parameters unless stated: H 8/2/2/4, V 4/1/1/2, CE_PIX = 1.
- Reset release with no adjustment → HPOS runs 0..15; HBLK = 1 for HPOS 8..15; HSYN = 0 for HPOS 10..11; LINE_START pulses when HPOS becomes 0.
- Full frame → VBLK = 1 for VPOS 4..7; VSYN = 0 on line 5; VBL_IRQ pulses exactly once, when VPOS becomes 4; frame length 128 CE cycles.
- H_ADJ = +7 → effective front porch clamped to 5; HSYN = 0 at HPOS 13..14. H_ADJ = -4 → clamped to 1; HSYN = 0 at HPOS 9..10.
- H_ADJ changed mid-frame → sync position unchanged until the frame start; shifted from the next frame onward. With VTG_ADJUST_EN undefined the sync never moves.
- CE_PIX pattern 1,0,0,1 with iRGB = 0xABC in the active region → HPOS steps once per CE; oRGB = 0xABC one pixel later; oRGB = 0 while blanked.
- RESET pulsed at VPOS = 2, HPOS = 5 → all outputs take their reset values immediately; the first post-release CE gives HPOS = 1, VPOS = 0. Default parameters give a 384 × 263 frame.
